// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared width, state and counter definitions for the sequential multiplier
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    function automatic int mul_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int MUL_CNT_W = mul_cnt_width(MUL_WIDTH);

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth add/subtract and arithmetic shift
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic [WIDTH:0]   a_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_m1_in,
    input  logic [WIDTH:0]   m_in,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH-1:0] q_out,
    output logic             q_m1_out
);

    logic [WIDTH:0] sum;

    // Recode {Q[0], q_-1}, then shift {A, Q, q_-1} right one place keeping A's sign
    always_comb begin
        sum = a_in;
        case ({q_in[0], q_m1_in})
            2'b01:   sum = a_in + m_in;
            2'b10:   sum = a_in - m_in;
            default: sum = a_in;
        endcase
        a_out    = {sum[WIDTH], sum[WIDTH:1]};
        q_out    = {sum[0], q_in[WIDTH-1:1]};
        q_m1_out = q_in[0];
    end

endmodule

// File: rtl/multiplier.sv
// rtl/multiplier.sv - sequential signed WIDTH x WIDTH Booth multiplier with overflow flag
module multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] Out,
    output logic             Overflow
);

    localparam int CNT_W = mul_cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   m_q, m_d;
    logic [WIDTH:0]   a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             q_m1_q, q_m1_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;

    logic [WIDTH:0]   a_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic             q_m1_nxt;
    logic [WIDTH+1:0] prod_top;

    booth_step #(.WIDTH(WIDTH)) u_booth_step (
        .a_in     (a_q),
        .q_in     (q_q),
        .q_m1_in  (q_m1_q),
        .m_in     (m_q),
        .a_out    (a_nxt),
        .q_out    (q_nxt),
        .q_m1_out (q_m1_nxt)
    );

    // A[WIDTH] always matches A[WIDTH-1] once the product is complete, so it can join the sign check
    assign prod_top = {a_nxt, q_nxt[WIDTH-1]};

    // Next-state, operand capture, iteration and result update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        a_d     = a_q;
        q_d     = q_q;
        q_m1_d  = q_m1_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    m_d     = {In1[WIDTH-1], In1};
                    q_d     = In2;
                    a_d     = '0;
                    q_m1_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d    = a_nxt;
                q_d    = q_nxt;
                q_m1_d = q_m1_nxt;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    out_d   = q_nxt;
                    ovf_d   = !((&prod_top) || !(|prod_top));
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d != RUN);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            m_q     <= '0;
            a_q     <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            a_q     <= a_d;
            q_q     <= q_d;
            q_m1_q  <= q_m1_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign Out      = out_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_multiplier.sv
// tb/tb_multiplier.sv - self-checking bench for the sequential signed multiplier
module tb_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] In1;
    logic [31:0] In2;
    logic        ready;
    logic        done;
    logic [31:0] Out;
    logic        Overflow;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eo;
        logic        ev;
        string       name;
    } vec_t;

    vec_t tv[8];

    multiplier #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .In1      (In1),
        .In2      (In2),
        .ready    (ready),
        .done     (done),
        .Out      (Out),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact signed product with plain 64-bit arithmetic
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] o, output logic v);
        longint p;
        logic [63:0] pu;
        p  = longint'($signed(a)) * longint'($signed(b));
        pu = p;
        o  = pu[31:0];
        v  = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    endtask

    // Caller is at a negedge; start is sampled at the following posedge
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        In1   = a;
        In2   = b;
        @(posedge clk);
    endtask

    // Returns at the negedge inside the done cycle
    task automatic wait_result(input logic [31:0] eo, input logic ev, input string name, input bit poke);
        int cyc;
        bit rbad;
        bit seen;
        cyc  = 0;
        rbad = 0;
        seen = 0;
        while (cyc < 40) begin
            @(negedge clk);
            if (poke && (cyc == 5 || cyc == 12)) begin
                start = 1'b1;
                In1   = $urandom;
                In2   = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                seen = 1;
                break;
            end
            if (ready) rbad = 1;
            @(posedge clk);
            cyc++;
        end
        chk({name, "_done_seen"}, 64'(seen), 64'(1));
        chk({name, "_latency"}, 64'(cyc), 64'(32));
        chk({name, "_out"}, 64'(Out), 64'(eo));
        chk({name, "_ovf"}, 64'(Overflow), 64'(ev));
        chk({name, "_ready_low_in_run"}, 64'(rbad), 64'(0));
        chk({name, "_ready_at_done"}, 64'(ready), 64'(1));
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eo, input logic ev, input string name);
        launch(a, b);
        wait_result(eo, ev, name, 0);
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 64'(done), 64'(0));
    endtask

    initial begin
        logic [31:0] eo, eo2;
        logic        ev, ev2;
        logic [31:0] ra, rb;
        int          dcount;
        logic [31:0] specials[6];

        tv[0] = '{32'd5,          32'd7,          32'd35,         1'b0, "five_x_seven"};
        tv[1] = '{32'd1,          32'hFFFFFFFB,   32'hFFFFFFFB,   1'b0, "one_x_m5"};
        tv[2] = '{32'd2147483647, 32'd1999999999, 32'd147483649,  1'b1, "big_x_big"};
        tv[3] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1, "min_x_m1"};
        tv[4] = '{32'h80000000,   32'd1,          32'h80000000,   1'b0, "min_x_1"};
        tv[5] = '{32'd0,          32'hDEADBEEF,   32'd0,          1'b0, "zero_x_x"};
        tv[6] = '{32'h80000000,   32'h80000000,   32'd0,          1'b1, "min_x_min"};
        tv[7] = '{32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          1'b0, "m1_x_m1"};

        specials[0] = 32'h80000000;
        specials[1] = 32'h7FFFFFFF;
        specials[2] = 32'hFFFFFFFF;
        specials[3] = 32'd0;
        specials[4] = 32'd1;
        specials[5] = 32'h00010000;

        rst_n = 1'b0;
        start = 1'b0;
        In1   = '0;
        In2   = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(ready), 64'(1));
        chk("reset_done", 64'(done), 64'(0));
        chk("reset_out", 64'(Out), 64'(0));
        chk("reset_ovf", 64'(Overflow), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].eo, tv[i].ev, tv[i].name);
        end

        // Back-to-back: restart in the done cycle
        launch(32'd12345, 32'hFFFF0000);
        model(32'd12345, 32'hFFFF0000, eo, ev);
        wait_result(eo, ev, "b2b_first", 0);
        launch(32'h40000000, 32'd4);
        model(32'h40000000, 32'd4, eo2, ev2);
        wait_result(eo2, ev2, "b2b_second", 0);
        @(negedge clk);
        chk("b2b_done_one_cycle", 64'(done), 64'(0));

        // Start pulses during RUN must not disturb the computation
        launch(32'hFFFFFF00, 32'd300);
        model(32'hFFFFFF00, 32'd300, eo, ev);
        wait_result(eo, ev, "run_poke", 1);
        @(negedge clk);

        // Outputs hold while idle and inputs wander
        for (int i = 0; i < 5; i++) begin
            In1 = $urandom;
            In2 = $urandom;
            @(negedge clk);
            chk("hold_out", 64'(Out), 64'(eo));
            chk("hold_ovf", 64'(Overflow), 64'(ev));
        end

        // Asynchronous reset at RUN iteration 10 aborts the operation
        launch(32'd77, 32'd99);
        repeat (10) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 rst_n = 1'b0;
        #1;
        chk("abort_out", 64'(Out), 64'(0));
        chk("abort_ovf", 64'(Overflow), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_ready", 64'(ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'(0));
        model(32'hFFFFFFF9, 32'd6, eo, ev);
        run_op(32'hFFFFFFF9, 32'd6, eo, ev, "after_abort");

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom_range(0, 65535) - 32'd32768; rb = $urandom_range(0, 65535) - 32'd32768; end
                2: begin ra = specials[$urandom_range(0, 5)]; rb = $urandom; end
                default: begin ra = specials[$urandom_range(0, 5)]; rb = specials[$urandom_range(0, 5)]; end
            endcase
            model(ra, rb, eo, ev);
            run_op(ra, rb, eo, ev, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
